gam_edge_age_ctrl: RTL
======================

# gam_edge_age_ctrl

Sequencer for the memory-layer connection memory of the GAM learning path. After the learning unit picks a winner node s1 and second winner s2 in a class, this block ages every edge touching s1 and prunes edges whose age exceeds AGE_MAX. It then creates or refreshes the s1–s2 edge with age 0. It is the only writer of the connection memory during learning and drives it through a single synchronous-read port.

## Interface
- NODE_COUNT, 10, nodes per class; valid node indices 1..NODE_COUNT
- CLASS_COUNT, 4, classes; valid class indices 1..CLASS_COUNT
- AGE_MAX, 2, an edge is pruned when its incremented age > AGE_MAX
- AGE_W, 8, stored age width; unsigned
- CW = $clog2(CLASS_COUNT+1), NW = $clog2(NODE_COUNT+1) (derived)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- cls  in  CW  class index, captured on accepted start
- s1  in  NW  winner node, captured on accepted start
- s2  in  NW  second-winner node, captured on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- err  out  1  one-cycle pulse coincident with done when the request is illegal
- pruned  out  NW  number of edges pruned in the last operation; held until next accepted start
- mem_en  out  1  connection memory access strobe
- mem_we  out  1  write enable (valid with mem_en)
- mem_cls  out  CW  class address
- mem_row  out  NW  row node address
- mem_col  out  NW  column node address
- mem_wdata  out  1+AGE_W  {presence, age}
- mem_rdata  in  1+AGE_W  {presence, age}; valid the cycle after a read strobe

## Operation
- States: IDLE, CHECK, RD, EVAL, WR_FWD, WR_REV, LINK_FWD, LINK_REV, DONE.
- IDLE: on start, capture cls/s1/s2, clear pruned, set j=1, go to CHECK.
- CHECK: illegal if any of cls∉1..CLASS_COUNT, s1 or s2 ∉1..NODE_COUNT, or s1==s2. An illegal request goes to DONE with err and performs no memory access. A legal request goes to RD.
- RD: if j==s1, skip. Otherwise read (cls,s1,j) and go to EVAL.
- EVAL: absent edge → next j. Present edge → a = age+1, saturating at 2^AGE_W−1.
  - a > AGE_MAX: write {0,0}; pruned++.
  - otherwise: write {1,a}.
- WR_FWD writes (cls,s1,j). WR_REV writes the same word to (cls,j,s1), keeping the memory symmetric. Then go to the next j.
- Next j: j==NODE_COUNT → LINK_FWD; else j+1 → RD.
- LINK_FWD writes {1,0} to (cls,s1,s2). LINK_REV writes {1,0} to (cls,s2,s1). Then go to DONE.
- The s1–s2 edge is aged/pruned in the scan like any other edge, then always re-established with age 0 by LINK.
- DONE: done=1 for one cycle, then IDLE.
- start while busy or in DONE is ignored, with no queueing.
- Diagonal entries (s1,s1) are never accessed.

## Timing
- Reset values: busy=0, done=0, err=0, pruned=0, mem_en=0, mem_we=0, all address/data outputs 0; state IDLE.
- All outputs are registered.
- Per j: skipped 1 cycle; absent 2 cycles (RD, EVAL); present 4 cycles (RD, EVAL, WR_FWD, WR_REV).
- Legal latency, start to done: 1 (CHECK) + Σ per-j + 2 (LINK) + 1.
- Illegal latency: done/err 2 cycles after start.
- Reset asserted mid-operation: immediate return to IDLE, outputs to reset values. Partially written edges are not rolled back; the learning unit reissues the request.

## Structure
- GAM_package gains the connection word typedef (presence bit + AGE_W age), the state enum, and AGE_W. NODE_COUNT, CLASS_COUNT and AGE_MAX already live there.
- One natural sub-module: gam_age_update (combinational). Input is the read word; outputs are the next word and a prune flag, implementing the saturation and AGE_MAX compare. It is unit-testable standalone.

## Test plan
- Empty class 1, s1=3, s2=5 → only (1,3,5) and (1,5,3) are written, both = {1,0}. pruned=0. done 1+9·2+1+2+1=23 cycles after start.
- Class 2, s1=1, edges 1–4 age 0 and 1–7 age 2, s2=4 → 1–7 pruned both directions. 1–4 ends {1,0}. pruned=1.
- Class 1, s1=2, edge 2–6 age 1, s2=9 → (2,6) and (6,2) = {1,2}. (2,9) and (9,2) = {1,0}. pruned=0.
- Illegal requests s1=s2=4, s1=0, cls=5 → err and done 2 cycles after start; mem_en never asserted.
- start pulsed while busy with different operands → ignored; first operation's results unchanged.
- rst_n low for 1 cycle during WR_FWD → all outputs 0 next cycle; a new start then completes normally.

Source files
------------

// File: rtl/gam_edge_age_ctrl_pkg.sv
// Shared constants, connection word layout and sequencer states for the
// GAM edge-ageing path.
package gam_edge_age_ctrl_pkg;

    localparam int NODE_COUNT  = 10;
    localparam int CLASS_COUNT = 4;
    localparam int AGE_MAX     = 2;
    localparam int AGE_W       = 8;
    localparam int CW          = $clog2(CLASS_COUNT + 1);
    localparam int NW          = $clog2(NODE_COUNT + 1);

    // One connection memory entry: presence flag above the edge age.
    typedef struct packed {
        logic             present;
        logic [AGE_W-1:0] age;
    } conn_word_t;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        RD,
        EVAL,
        WR_FWD,
        WR_REV,
        LINK_FWD,
        LINK_REV,
        DONE
    } state_t;

    // A request is usable only with in-range indices and two distinct nodes.
    function automatic logic request_legal(input logic [CW-1:0] c,
                                           input logic [NW-1:0] a,
                                           input logic [NW-1:0] b);
        return (c >= CW'(1)) && (c <= CW'(CLASS_COUNT)) &&
               (a >= NW'(1)) && (a <= NW'(NODE_COUNT)) &&
               (b >= NW'(1)) && (b <= NW'(NODE_COUNT)) &&
               (a != b);
    endfunction

endpackage

// File: rtl/gam_edge_age_ctrl_age_update.sv
// Combinational edge ageing: increments a present edge's age with saturation
// and flags it for pruning once the new age passes AGE_MAX.
module gam_age_update
    import gam_edge_age_ctrl_pkg::*;
(
    input  conn_word_t rd_word,
    output conn_word_t next_word,
    output logic       prune
);

    logic [AGE_W-1:0] inc_age;

    // Age the edge; a pruned or absent edge becomes the all-zero word.
    always_comb begin
        inc_age   = (rd_word.age == '1) ? rd_word.age : rd_word.age + AGE_W'(1);
        prune     = rd_word.present && (inc_age > AGE_W'(AGE_MAX));
        next_word = '0;
        if (rd_word.present && !prune) begin
            next_word.present = 1'b1;
            next_word.age     = inc_age;
        end
    end

endmodule

// File: rtl/gam_edge_age_ctrl.sv
// Learning-path sequencer for the connection memory: ages every edge of the
// winner s1, prunes stale ones, then (re)links s1-s2 with age 0.
module gam_edge_age_ctrl
    import gam_edge_age_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] cls,
    input  logic [NW-1:0] s1,
    input  logic [NW-1:0] s2,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [NW-1:0] pruned,
    output logic          mem_en,
    output logic          mem_we,
    output logic [CW-1:0] mem_cls,
    output logic [NW-1:0] mem_row,
    output logic [NW-1:0] mem_col,
    output logic [AGE_W:0] mem_wdata,
    input  logic [AGE_W:0] mem_rdata
);

    localparam logic [NW-1:0]  LAST_NODE = NW'(NODE_COUNT);
    localparam logic [AGE_W:0] LINK_WORD = {1'b1, {AGE_W{1'b0}}};

    state_t         state_q, state_d;
    logic [NW-1:0]  j_q, j_d;
    logic [CW-1:0]  cls_q;
    logic [NW-1:0]  s1_q, s2_q;
    conn_word_t     rd_word, upd_word;
    logic           upd_prune;

    logic           busy_d, done_d, err_d, mem_en_d, mem_we_d;
    logic [CW-1:0]  mem_cls_d;
    logic [NW-1:0]  mem_row_d, mem_col_d;
    logic [AGE_W:0] mem_wdata_d;

    assign rd_word = mem_rdata;

    gam_age_update u_age_update (
        .rd_word   (rd_word),
        .next_word (upd_word),
        .prune     (upd_prune)
    );

    // Next-state/scan-index logic, then the registered output values derived
    // from the state being entered so every output comes straight off a flop.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CHECK;
                    j_d     = NW'(1);
                end
            end
            CHECK: state_d = request_legal(cls_q, s1_q, s2_q) ? RD : DONE;
            RD: begin
                if (j_q == s1_q) begin
                    if (j_q == LAST_NODE) state_d = LINK_FWD;
                    else begin
                        state_d = RD;
                        j_d     = j_q + NW'(1);
                    end
                end else begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (rd_word.present) state_d = WR_FWD;
                else if (j_q == LAST_NODE) state_d = LINK_FWD;
                else begin
                    state_d = RD;
                    j_d     = j_q + NW'(1);
                end
            end
            WR_FWD: state_d = WR_REV;
            WR_REV: begin
                if (j_q == LAST_NODE) state_d = LINK_FWD;
                else begin
                    state_d = RD;
                    j_d     = j_q + NW'(1);
                end
            end
            LINK_FWD: state_d = LINK_REV;
            LINK_REV: state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE) && (state_d != DONE);
        done_d      = (state_d == DONE);
        err_d       = (state_q == CHECK) && (state_d == DONE);
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_cls_d   = '0;
        mem_row_d   = '0;
        mem_col_d   = '0;
        mem_wdata_d = '0;
        case (state_d)
            RD: begin
                if (j_d != s1_q) begin
                    mem_en_d  = 1'b1;
                    mem_cls_d = cls_q;
                    mem_row_d = s1_q;
                    mem_col_d = j_d;
                end
            end
            WR_FWD: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_cls_d   = cls_q;
                mem_row_d   = s1_q;
                mem_col_d   = j_q;
                mem_wdata_d = upd_word;
            end
            WR_REV: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_cls_d   = cls_q;
                mem_row_d   = j_q;
                mem_col_d   = s1_q;
                mem_wdata_d = mem_wdata;
            end
            LINK_FWD: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_cls_d   = cls_q;
                mem_row_d   = s1_q;
                mem_col_d   = s2_q;
                mem_wdata_d = LINK_WORD;
            end
            LINK_REV: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_cls_d   = cls_q;
                mem_row_d   = s2_q;
                mem_col_d   = s1_q;
                mem_wdata_d = LINK_WORD;
            end
            default: ;
        endcase
    end

    // State, scan index and the request operands captured on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            cls_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            if (state_q == IDLE && start) begin
                cls_q <= cls;
                s1_q  <= s1;
                s2_q  <= s2;
            end
        end
    end

    // Prune counter: cleared by a new request, bumped for each stale edge seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pruned <= '0;
        end else if (state_q == IDLE && start) begin
            pruned <= '0;
        end else if (state_q == EVAL && upd_prune) begin
            pruned <= pruned + NW'(1);
        end
    end

    // Output register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_cls   <= '0;
            mem_row   <= '0;
            mem_col   <= '0;
            mem_wdata <= '0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_cls   <= mem_cls_d;
            mem_row   <= mem_row_d;
            mem_col   <= mem_col_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule
